// File: rtl/cdu_drive_pulser.sv
// Multi-channel CDU/gyro drive-pulse generator: per-channel ones'-complement counts
// are paced out as fixed-width plus/minus pulses on each enabled rate strobe.
module cdu_drive_pulser #(
  parameter int NCH = 3,
  parameter int W   = 15,
  parameter int PW  = 2,
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           CLOCK,
  input  logic           rst_,
  input  logic           WE,
  input  logic [SW-1:0]  WSEL,
  input  logic [W-1:0]   WDATA,
  input  logic [NCH-1:0] EN,
  input  logic           RATE,
  input  logic [SW-1:0]  RSEL,
  output logic [W-1:0]   RDATA,
  output logic [NCH-1:0] DP,
  output logic [NCH-1:0] DM,
  output logic [NCH-1:0] BUSY,
  output logic [NCH-1:0] DONE
);

  localparam int TW = $clog2(PW + 1);
  localparam logic [W-2:0] M_ONE = (W-1)'(1);
  localparam logic [TW-1:0] T_ONE = TW'(1);
  localparam logic [TW-1:0] T_PW  = TW'(PW);

  logic [NCH-1:0] r_s;
  logic [NCH-1:0] r_ps;
  logic [NCH-1:0] r_done;
  logic [W-2:0]   r_m [NCH];
  logic [TW-1:0]  r_t [NCH];

  logic [NCH-1:0] w_ld;
  logic [NCH-1:0] w_go;

  // A coincident load on the same channel suppresses that channel's strobe.
  always_comb begin
    w_ld = '0;
    w_go = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      w_ld[i] = WE && (WSEL == SW'(i));
      w_go[i] = RATE && EN[i] && (r_m[i] != '0) && (r_t[i] == '0) && !w_ld[i];
    end
  end

  always_ff @(posedge CLOCK or negedge rst_) begin
    if (!rst_) begin
      r_s    <= '0;
      r_ps   <= '0;
      r_done <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        r_m[i] <= '0;
        r_t[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_done[i] <= w_go[i] && (r_m[i] == M_ONE);
        if (w_ld[i]) begin
          r_s[i] <= WDATA[W-1];
          r_m[i] <= WDATA[W-1] ? ~WDATA[W-2:0] : WDATA[W-2:0];
        end else if (w_go[i]) begin
          r_m[i] <= r_m[i] - M_ONE;
        end
        // Polarity is latched separately so a reload mid-pulse cannot flip it.
        if (w_go[i]) begin
          r_t[i]  <= T_PW;
          r_ps[i] <= r_s[i];
        end else if (r_t[i] != '0) begin
          r_t[i] <= r_t[i] - T_ONE;
        end
      end
    end
  end

  always_comb begin
    DP   = '0;
    DM   = '0;
    BUSY = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      DP[i]   = (r_t[i] != '0) && !r_ps[i];
      DM[i]   = (r_t[i] != '0) && r_ps[i];
      BUSY[i] = (r_m[i] != '0);
    end
    DONE = r_done;
  end

  // An exhausted negative count reads back as +0, never -0.
  always_comb begin
    RDATA = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (RSEL == SW'(i)) begin
        if (r_s[i] && (r_m[i] != '0)) RDATA = {1'b1, ~r_m[i]};
        else                          RDATA = {1'b0, r_m[i]};
      end
    end
  end

endmodule

// File: tb/tb_cdu_drive_pulser.sv
// Bench for cdu_drive_pulser: fixed vector table, hand-built corner sequences and
// random traffic checked against a signed-integer reference model.
module tb_cdu_drive_pulser;

  localparam int NCH = 3;
  localparam int W   = 15;
  localparam int PW  = 2;

  logic            CLOCK;
  logic            rst_;
  logic            WE;
  logic [1:0]      WSEL;
  logic [W-1:0]    WDATA;
  logic [NCH-1:0]  EN;
  logic            RATE;
  logic [1:0]      RSEL;
  logic [W-1:0]    RDATA;
  logic [NCH-1:0]  DP, DM, BUSY, DONE;

  cdu_drive_pulser #(.NCH(NCH), .W(W), .PW(PW)) dut (
    .CLOCK(CLOCK), .rst_(rst_), .WE(WE), .WSEL(WSEL), .WDATA(WDATA), .EN(EN),
    .RATE(RATE), .RSEL(RSEL), .RDATA(RDATA), .DP(DP), .DM(DM), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: signed remaining count, last cycle of the current pulse.
  int val [NCH];
  int hi_until [NCH];
  bit pneg [NCH];
  bit mdone [NCH];
  int cyc = 0;

  logic [NCH-1:0] cur_en;
  logic [NCH-1:0] prev_dp, prev_dm;
  int np [NCH];
  int nd [NCH];

  typedef struct {
    logic           we;
    logic [1:0]     wsel;
    logic [W-1:0]   wdata;
    logic [NCH-1:0] en;
    logic           rate;
    logic [1:0]     rsel;
    logic [NCH-1:0] dp, dm, busy, done;
    logic [W-1:0]   rdata;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic we, input logic [1:0] wsel, input logic [W-1:0] wdata,
                     input logic [NCH-1:0] en, input logic rate, input logic [1:0] rsel,
                     input logic [NCH-1:0] dp, input logic [NCH-1:0] dm,
                     input logic [NCH-1:0] busy, input logic [NCH-1:0] done,
                     input logic [W-1:0] rdata);
    tbl.push_back('{we, wsel, wdata, en, rate, rsel, dp, dm, busy, done, rdata});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [W-1:0] d);
    logic [W-2:0] lo;
    if (d[W-1]) begin
      lo = ~d[W-2:0];
      return -int'(lo);
    end
    lo = d[W-2:0];
    return int'(lo);
  endfunction

  function automatic int enc(input int v);
    if (v >= 0) return v;
    return (1 << W) - 1 + v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      val[i] = 0; hi_until[i] = -1; pneg[i] = 1'b0; mdone[i] = 1'b0;
      np[i] = 0; nd[i] = 0;
    end
    prev_dp = '0;
    prev_dm = '0;
  endtask

  task automatic step(input logic we, input logic [1:0] wsel, input logic [W-1:0] wdata,
                      input logic rate, input logic [1:0] rsel);
    logic [NCH-1:0] e_dp, e_dm, e_busy, e_done;
    int e_rd;
    @(negedge CLOCK);
    WE = we; WSEL = wsel; WDATA = wdata; EN = cur_en; RATE = rate; RSEL = rsel;
    @(posedge CLOCK);
    for (int i = 0; i < NCH; i++) begin
      mdone[i] = 1'b0;
      if (we && (int'(wsel) == i)) begin
        val[i] = dec(wdata);
      end else if (rate && cur_en[i] && val[i] != 0 && cyc > hi_until[i]) begin
        pneg[i] = (val[i] < 0);
        hi_until[i] = cyc + PW;
        mdone[i] = (val[i] == 1 || val[i] == -1);
        val[i] = (val[i] > 0) ? val[i] - 1 : val[i] + 1;
      end
    end
    cyc++;
    #1;
    for (int i = 0; i < NCH; i++) begin
      e_dp[i]   = (cyc <= hi_until[i]) && !pneg[i];
      e_dm[i]   = (cyc <= hi_until[i]) && pneg[i];
      e_busy[i] = (val[i] != 0);
      e_done[i] = mdone[i];
    end
    e_rd = (int'(rsel) < NCH) ? enc(val[rsel]) : 0;
    chk("model_dp", 32'(DP), 32'(e_dp));
    chk("model_dm", 32'(DM), 32'(e_dm));
    chk("model_busy", 32'(BUSY), 32'(e_busy));
    chk("model_done", 32'(DONE), 32'(e_done));
    chk("model_rdata", 32'(RDATA), e_rd);
    for (int i = 0; i < NCH; i++) begin
      if ((DP[i] && !prev_dp[i]) || (DM[i] && !prev_dm[i])) np[i]++;
      if (DONE[i]) nd[i]++;
    end
    prev_dp = DP;
    prev_dm = DM;
  endtask

  task automatic idle(input int n, input logic [1:0] rsel);
    for (int k = 0; k < n; k++) step(1'b0, 2'd0, '0, 1'b0, rsel);
  endtask

  task automatic strobe(input logic [1:0] rsel);
    step(1'b0, 2'd0, '0, 1'b1, rsel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ = 1'b0; WE = 1'b0; WSEL = '0; WDATA = '0; EN = '0; RATE = 1'b0; RSEL = '0;
    cur_en = 3'b111;
    model_reset();
    #12;
    chk("reset_dp", 32'(DP), 0);
    chk("reset_dm", 32'(DM), 0);
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_done", 32'(DONE), 0);
    chk("reset_rdata", 32'(RDATA), 0);
    @(negedge CLOCK);
    rst_ = 1'b1;

    // we wsel wdata en rate rsel | dp dm busy done rdata
    add(1,0,15'h0003,7,0,0, 0,0,1,0,15'h0003);
    add(0,0,15'h0000,7,1,0, 1,0,1,0,15'h0002);
    add(0,0,15'h0000,7,0,0, 1,0,1,0,15'h0002);
    add(0,0,15'h0000,7,0,0, 0,0,1,0,15'h0002);
    add(0,0,15'h0000,7,1,0, 1,0,1,0,15'h0001);
    add(0,0,15'h0000,7,0,0, 1,0,1,0,15'h0001);
    add(0,0,15'h0000,7,0,0, 0,0,1,0,15'h0001);
    add(0,0,15'h0000,7,1,0, 1,0,0,1,15'h0000);
    add(0,0,15'h0000,7,0,0, 1,0,0,0,15'h0000);
    add(0,0,15'h0000,7,0,0, 0,0,0,0,15'h0000);
    add(0,0,15'h0000,7,1,0, 0,0,0,0,15'h0000);
    add(0,0,15'h0000,7,0,0, 0,0,0,0,15'h0000);
    add(1,1,15'h7FFC,7,0,1, 0,0,2,0,15'h7FFC);
    add(1,2,15'h7FFF,7,0,1, 0,0,2,0,15'h7FFC);
    add(0,0,15'h0000,7,1,1, 0,2,2,0,15'h7FFD);
    add(0,0,15'h0000,7,0,1, 0,2,2,0,15'h7FFD);
    add(0,0,15'h0000,7,0,1, 0,0,2,0,15'h7FFD);
    add(0,0,15'h0000,7,1,1, 0,2,2,0,15'h7FFE);
    add(0,0,15'h0000,7,0,1, 0,2,2,0,15'h7FFE);
    add(0,0,15'h0000,7,0,1, 0,0,2,0,15'h7FFE);
    add(0,0,15'h0000,7,1,1, 0,2,0,2,15'h0000);
    add(0,0,15'h0000,7,0,1, 0,2,0,0,15'h0000);
    add(0,0,15'h0000,7,0,1, 0,0,0,0,15'h0000);
    add(0,0,15'h0000,7,1,1, 0,0,0,0,15'h0000);
    add(1,0,15'h0005,7,0,0, 0,0,1,0,15'h0005);
    add(1,0,15'h0002,7,1,0, 0,0,1,0,15'h0002);
    add(0,0,15'h0000,7,1,0, 1,0,1,0,15'h0001);
    add(0,0,15'h0000,7,0,0, 1,0,1,0,15'h0001);
    add(0,0,15'h0000,7,0,0, 0,0,1,0,15'h0001);
    add(0,0,15'h0000,7,1,0, 1,0,0,1,15'h0000);
    add(0,0,15'h0000,7,0,0, 1,0,0,0,15'h0000);
    add(0,0,15'h0000,7,0,0, 0,0,0,0,15'h0000);
    add(0,0,15'h0000,7,0,3, 0,0,0,0,15'h0000);
    add(1,0,15'h0007,7,0,3, 0,0,1,0,15'h0000);
    add(1,3,15'h0005,7,0,0, 0,0,1,0,15'h0007);
    add(1,0,15'h7FFF,7,0,0, 0,0,0,0,15'h0000);

    foreach (tbl[k]) begin
      cur_en = tbl[k].en;
      step(tbl[k].we, tbl[k].wsel, tbl[k].wdata, tbl[k].rate, tbl[k].rsel);
      chk($sformatf("tbl%0d_dp", k), 32'(DP), 32'(tbl[k].dp));
      chk($sformatf("tbl%0d_dm", k), 32'(DM), 32'(tbl[k].dm));
      chk($sformatf("tbl%0d_busy", k), 32'(BUSY), 32'(tbl[k].busy));
      chk($sformatf("tbl%0d_done", k), 32'(DONE), 32'(tbl[k].done));
      chk($sformatf("tbl%0d_rdata", k), 32'(RDATA), 32'(tbl[k].rdata));
    end

    // Enable freeze and resume.
    cur_en = 3'b111;
    for (int i = 0; i < NCH; i++) begin np[i] = 0; nd[i] = 0; end
    step(1'b1, 2'd0, 15'h0004, 1'b0, 2'd0);
    strobe(2'd0); idle(2, 2'd0);
    cur_en = 3'b110;
    repeat (3) begin strobe(2'd0); idle(2, 2'd0); end
    chk("freeze_pulses", np[0], 1);
    chk("freeze_rdata", 32'(RDATA), 32'h0003);
    cur_en = 3'b111;
    repeat (3) begin strobe(2'd0); idle(2, 2'd0); end
    chk("resume_pulses", np[0], 4);
    chk("resume_done", nd[0], 1);
    chk("resume_rdata", 32'(RDATA), 0);

    // Strobes closer than PW+1 cycles.
    for (int i = 0; i < NCH; i++) begin np[i] = 0; nd[i] = 0; end
    step(1'b1, 2'd0, 15'h0004, 1'b0, 2'd0);
    repeat (8) begin strobe(2'd0); idle(1, 2'd0); end
    idle(2, 2'd0);
    chk("fast_pulses", np[0], 4);
    chk("fast_done", nd[0], 1);
    chk("fast_rdata", 32'(RDATA), 0);

    // Largest magnitudes in both signs.
    step(1'b1, 2'd1, 15'h3FFF, 1'b0, 2'd1);
    strobe(2'd1); idle(2, 2'd1);
    chk("max_pos_rdata", 32'(RDATA), 32'h3FFE);
    step(1'b1, 2'd1, 15'h4000, 1'b0, 2'd1);
    strobe(2'd1); idle(2, 2'd1);
    chk("max_neg_rdata", 32'(RDATA), 32'h4001);

    // Reset in the second cycle of a minus pulse.
    step(1'b1, 2'd1, 15'h7FFC, 1'b0, 2'd1);
    strobe(2'd1);
    idle(1, 2'd1);
    chk("pre_reset_dm", 32'(DM), 32'h2);
    #1 rst_ = 1'b0;
    #1;
    chk("async_reset_dm", 32'(DM), 0);
    chk("async_reset_busy", 32'(BUSY), 0);
    chk("async_reset_done", 32'(DONE), 0);
    model_reset();
    @(negedge CLOCK);
    rst_ = 1'b1;
    for (int r = 0; r < NCH; r++) idle(1, 2'(r));
    repeat (3) begin strobe(2'd1); idle(2, 2'd1); end
    chk("post_reset_pulses", np[0] + np[1] + np[2], 0);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      logic           we, rate;
      logic [1:0]     wsel, rsel;
      logic [W-1:0]   wd;
      int unsigned    mode;
      we   = ($urandom_range(0, 5) == 0);
      wsel = 2'($urandom_range(0, 3));
      rsel = 2'($urandom_range(0, 3));
      rate = ($urandom_range(0, 2) == 0);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       wd = W'($urandom);
        1:       wd = W'($urandom_range(0, 6));
        2:       wd = ~W'($urandom_range(0, 6));
        default: wd = ($urandom_range(0, 1) == 0) ? 15'h7FFF : 15'h0000;
      endcase
      if ($urandom_range(0, 15) == 0) cur_en = NCH'($urandom);
      step(we, wsel, wd, rate, rsel);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdu_drive_pulser.md
# cdu_drive_pulser

Parametrised multi-channel drive-pulse generator. It is the generalised successor to the fixed three-axis CDU drive logic (CDUXDP/CDUXDM, CDUYDP/CDUYDM, CDUZDP/CDUZDM). Software writes a signed ones'-complement count per channel. On each rate strobe, the block emits one plus or minus pulse per active channel and counts the magnitude down to zero. It sits between the channel-write decode and the CDU/gyro drive outputs and adds per-channel readback, completion pulses and a configurable pulse width.

## Interface
Parameters:
- NCH, 3, number of drive channels (1–8)
- W, 15, count word width including sign bit (ones' complement)
- PW, 2, output pulse width in CLOCK cycles (≥1)

Ports (clock/reset first; SW = max(1, clog2(NCH))):
- CLOCK  in  1  system clock; all state changes on its rising edge
- rst_  in  1  asynchronous, active-low reset
- WE  in  1  load strobe, one cycle
- WSEL  in  SW  channel to load
- WDATA  in  W  ones'-complement count
- EN  in  NCH  per-channel drive enable (level)
- RATE  in  1  single-cycle pulse-rate strobe
- RSEL  in  SW  readback channel select
- RDATA  out  W  remaining count of channel RSEL, combinational
- DP  out  NCH  plus drive pulses
- DM  out  NCH  minus drive pulses
- BUSY  out  NCH  channel magnitude ≠ 0
- DONE  out  NCH  one-cycle pulse when a channel's count is exhausted by pulsing

## Operation
- Per-channel state:
  - sign bit `s`
  - magnitude `m` (W-1 bits)
  - pulse timer `t` (0..PW)
- Load: on WE, channel WSEL takes `s` = WDATA[W-1].
  - If `s`=0: `m` = WDATA[W-2:0].
  - If `s`=1: `m` = ~WDATA[W-2:0].
  - +0 and −0 both give `m`=0 (idle).
  - Load overwrites any remaining count. A pulse already in flight completes.
  - WSEL ≥ NCH: write ignored.
- Strobe: on a RATE cycle, each channel with EN=1, `m`≠0, `t`=0 and no coincident load:
  - decrements `m`;
  - sets `t`=PW.
- Strobe is ignored by a channel that fails any of these conditions. It is not queued.
- Output: DP[i] = (`t`≠0 && `s`=0) and DM[i] = (`t`≠0 && `s`=1), registered. `t` decrements each cycle while nonzero.
- Sign is captured at pulse start. A load during a pulse does not change that pulse's polarity.
- DONE[i]: asserted for exactly one cycle, in the cycle after a strobe decrements `m` from 1 to 0. It is never asserted by a load (including a load of ±0).
- BUSY[i] = (`m`≠0), registered state.
- RDATA:
  - `s`=0 or `m`=0: {0, `m`}
  - otherwise: {1, ~`m`}
  - Remaining zero always reads +0.
  - RSEL ≥ NCH reads 0.
- EN low: count is frozen and no new pulses start. An in-flight pulse finishes. Re-enabling resumes from the frozen count.

## Timing
- Reset (async assert, sync-safe release) clears all state: DP=DM=BUSY=DONE=0, `m`=0, `t`=0, RDATA=0.
- Reset mid-pulse truncates the pulse immediately.
- Pulse latency: RATE at cycle n → DP/DM high for cycles n+1 .. n+PW. BUSY/`m` update at n+1. DONE high at n+1 only.
- Load latency: WE at n → BUSY and RDATA reflect the new count from n+1.
- WE and RATE in the same cycle on the same channel: the load wins and no pulse starts. Other channels strobe normally.
- RATE spacing below PW+1 cycles: channels still in a pulse skip that strobe (`m` unchanged).
- The maximum count 2^(W-1)−1 decrements without wrap. `m` never underflows.

## Test plan
- NCH=3, W=15, PW=2; load ch0 = 0x0003, EN=3'b111, 4 RATE strobes 8 cycles apart → 3 DP[0] pulses, each 2 cycles wide starting 1 cycle after RATE. DONE[0] pulses once, at the 3rd strobe+1. The 4th strobe produces nothing. RDATA(ch0)=0x0000, BUSY[0]=0.
- Load ch1 = 0x7FFC (−3) and ch2 = 0x7FFF (−0), 4 strobes → 3 DM[1] pulses and no DP[1]. Ch2 has no pulses, no DONE and BUSY[2]=0. After 1 strobe, RDATA(ch1)=0x7FFD.
- Load ch0 = 0x0005, issue WE(ch0, 0x0002) in the same cycle as RATE → no pulse that strobe. The next two strobes give 2 DP[0] pulses, then DONE[0].
- Load ch0 = 0x0004, 1 strobe, drop EN[0], 3 strobes → exactly 1 pulse, RDATA=0x0003. Raise EN[0] and strobe 3 times → 3 more pulses, then DONE.
- Strobes 2 cycles apart with PW=2 on ch0 = 0x0004 → every other strobe is skipped. The pulse count equals the number of accepted strobes, and `m` never goes negative.
- Assert rst_=0 during the 2nd cycle of a DM pulse → DM, BUSY and DONE drop immediately. After release, RDATA=0 for all channels and strobes produce no pulses.
